// File: rtl/cva6_mt_pkg.sv
// Purpose : shared multithreading types for the CVA6 frontend, scheduler and scoreboard.
// Latency : n/a (types, parameters and helpers only).
// Backpressure: n/a.
package cva6_mt_pkg;

  // Thread-id width for a given context count; a single context still needs one bit.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumThreadsDflt = 4;
  localparam int unsigned TidWDflt       = tid_width(NumThreadsDflt);

  typedef logic [TidWDflt-1:0] tid_t;

  typedef enum logic {
    SCHED_RR     = 1'b0,
    SCHED_ICOUNT = 1'b1
  } sched_policy_e;

endpackage

// File: rtl/thread_prio_pick.sv
// Purpose : rotating-priority find-first over a thread mask, searching from start and wrapping.
// Latency : purely combinational.
// Backpressure: none; the result follows mask/start in the same cycle.
// Ports   : mask (candidate threads), start (highest-priority index),
//           found (any bit set), idx (winning thread, 0 when none).
module thread_prio_pick #(
  parameter int unsigned NumThreads = 4,
  parameter int unsigned TidW       = 2
) (
  input  logic [NumThreads-1:0] mask,
  input  logic [TidW-1:0]       start,
  output logic                  found,
  output logic [TidW-1:0]       idx
);

  // Duplicating the mask lets a plain right shift express the wrap-around.
  logic [2*NumThreads-1:0] dbl;
  logic [2*NumThreads-1:0] rot;

  always_comb begin
    dbl   = {mask, mask};
    rot   = dbl >> start;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NumThreads; off++) begin
      if (!found && rot[off]) begin
        found = 1'b1;
        idx   = TidW'((int'(start) + off) % NumThreads);
      end
    end
  end

endmodule

// File: rtl/cva6_thread_scheduler.sv
// Purpose : per-cycle fetch-thread selector (round-robin or ICOUNT) with per-thread in-flight counters.
// Latency : selection is combinational from registered state; counter/grant updates visible next cycle.
// Backpressure: last_grant advances only on sel_valid_o & fetch_ready_i, so a stalled offer holds.
// Ports   : thread_en_i/thread_stall_i gate eligibility; sel_valid_o/sel_tid_o is the offer;
//           issue_*/commit_*/flush_* maintain inflight_o; err_o flags counter over/underflow (sticky).
module cva6_thread_scheduler
  import cva6_mt_pkg::*;
#(
  parameter int unsigned NumThreads    = 4,
  parameter int unsigned MaxInflight   = 8,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Policy        = 0,
  parameter int unsigned TidW          = tid_width(NumThreads),
  parameter int unsigned CntW          = $clog2(MaxInflight + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumThreads-1:0]           thread_en_i,
  input  logic [NumThreads-1:0]           thread_stall_i,
  input  logic                            fetch_ready_i,
  output logic                            sel_valid_o,
  output logic [TidW-1:0]                 sel_tid_o,
  input  logic                            issue_i,
  input  logic [TidW-1:0]                 issue_tid_i,
  input  logic [NrCommitPorts-1:0]        commit_i,
  input  logic [NrCommitPorts*TidW-1:0]   commit_tid_i,
  input  logic                            flush_i,
  input  logic [TidW-1:0]                 flush_tid_i,
  output logic [NumThreads*CntW-1:0]      inflight_o,
  output logic [NumThreads-1:0]           err_o
);

  localparam sched_policy_e PolicyE = sched_policy_e'(Policy[0]);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxInflight);
  localparam int unsigned DecW = $clog2(NrCommitPorts + 1);
  localparam int unsigned UpW  = (CntW + 1 > DecW) ? CntW + 1 : DecW;

  logic [CntW-1:0]       cnt [NumThreads];
  logic [NumThreads-1:0] elig;
  logic [TidW-1:0]       last_grant;
  logic [TidW-1:0]       start;
  logic                  pick_found;
  logic [TidW-1:0]       pick_idx;

  always_comb begin
    for (int t = 0; t < NumThreads; t++) begin
      elig[t] = thread_en_i[t] & ~thread_stall_i[t] & (cnt[t] < MaxCnt);
    end
  end

  // Search starts just after the last accepted grant, wrapping to 0.
  assign start = (last_grant == TidW'(NumThreads - 1)) ? '0 : last_grant + 1'b1;

  generate
    if (PolicyE == SCHED_ICOUNT) begin : g_icount
      logic [CntW-1:0]       min_cnt;
      logic [NumThreads-1:0] min_mask;

      // Eligible threads are always below MaxCnt, so MaxCnt is a safe starting minimum.
      always_comb begin
        min_cnt = MaxCnt;
        for (int t = 0; t < NumThreads; t++) begin
          if (elig[t] && (cnt[t] < min_cnt)) min_cnt = cnt[t];
        end
        for (int t = 0; t < NumThreads; t++) begin
          min_mask[t] = elig[t] && (cnt[t] == min_cnt);
        end
      end

      thread_prio_pick #(.NumThreads(NumThreads), .TidW(TidW)) u_pick_ic (
        .mask  (min_mask),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
      );
    end else begin : g_rr
      thread_prio_pick #(.NumThreads(NumThreads), .TidW(TidW)) u_pick_rr (
        .mask  (elig),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
      );
    end
  endgenerate

  // A non-empty minimum mask exists exactly when some thread is eligible.
  assign sel_valid_o = pick_found;
  assign sel_tid_o   = pick_found ? pick_idx : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= TidW'(NumThreads - 1);
    end else if (pick_found && fetch_ready_i) begin
      last_grant <= pick_idx;
    end
  end

  // Tids outside 0..NumThreads-1 match no thread below and are therefore ignored.
  for (genvar t = 0; t < NumThreads; t++) begin : g_cnt
    logic            inc;
    logic [DecW-1:0] dec;
    logic [UpW-1:0]  up;
    logic [UpW-1:0]  diff;
    logic [CntW-1:0] nxt;
    logic            err_set;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    always_comb begin
      inc = issue_i && (issue_tid_i == TidW'(t));
      dec = '0;
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (commit_i[p] && (commit_tid_i[p*TidW +: TidW] == TidW'(t))) dec = dec + DecW'(1);
      end
      up      = UpW'(cnt_q) + UpW'(inc);
      diff    = up - UpW'(dec);
      nxt     = cnt_q;
      err_set = 1'b0;
      if (flush_i && (flush_tid_i == TidW'(t))) begin
        nxt = '0;
      end else if (UpW'(dec) > up) begin
        nxt     = '0;
        err_set = 1'b1;
      end else if (diff > UpW'(MaxInflight)) begin
        nxt     = MaxCnt;
        err_set = 1'b1;
      end else begin
        nxt = CntW'(diff);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= nxt;
        err_q <= err_q | err_set;
      end
    end

    assign cnt[t]                    = cnt_q;
    assign inflight_o[t*CntW +: CntW] = cnt_q;
    assign err_o[t]                  = err_q;
  end

endmodule
